sdram_port_arbiter: RTL
=======================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller between two bus requesters (port 0 and port 1) and an internal auto-refresh scheduler.
- Serialises one transaction at a time onto the controller command interface. Waits for the controller's ready, then returns read data and an acknowledge to the winning port.
- Sits between the system bus masters and the SDRAM controller/delay-generator datapath.

Parameters:
REFRESH_INTERVAL, 780, clk cycles between refresh requests (counter period)
TIMEOUT, 255, max cycles in WAIT before the transaction is aborted
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
reqN  in  1  port N (N=0,1) request; held high with fields stable until ackN
writeN  in  1  port N: 1=write, 0=read
addrN  in  AW  port N address
wdataN  in  DW  port N write data
sizeN  in  2  port N transfer size code, passed through
burstN  in  4  port N burst length code, passed through
ackN  out  1  port N one-cycle completion pulse
rdataN  out  DW  port N read data, valid while ackN=1 and held until next ackN
ctl_valid  out  1  one-cycle command strobe to controller
ctl_refresh  out  1  command is refresh; valid with ctl_valid
ctl_write, ctl_addr, ctl_wdata, ctl_size, ctl_burst  out  1/AW/DW/2/4  latched command fields, stable from ISSUE until return to IDLE
ctl_ready  in  1  controller completion pulse
ctl_rdata  in  DW  controller read data, valid with ctl_ready
grant  out  2  00 none, 01 port0, 10 port1, 11 refresh
busy  out  1  high in any state other than IDLE
timeout_err  out  1  one-cycle pulse on watchdog abort
ref_overrun  out  1  one-cycle pulse when interval expires while refresh still pending

Behaviour:
- Reset (reset=0, async):
  - State=IDLE; all outputs 0; ctl_* fields 0; rdataN 0.
  - Refresh counter 0; ref_pend 0; last_grant=1, so port 0 wins the first tie.
- Refresh counter:
  - Free-running 0..REFRESH_INTERVAL-1, counting in all states.
  - On terminal count: sets ref_pend and wraps to 0.
  - If ref_pend is already 1 at terminal count: ref_overrun pulses and ref_pend stays 1 (no queueing of a second refresh).
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitration, priority order:
  - ref_pend → refresh.
  - Otherwise, among eligible requests: single requester wins; on a tie, the port other than last_grant wins.
  - Port N is ineligible in the cycle its ackN is high, which prevents double issue.
  - On a win: latch the winner's fields into ctl_*, set grant, go to ISSUE.
  - Refresh winner: ctl_refresh=1, ctl_write=0, other fields 0.
- ISSUE: ctl_valid=1 for exactly one cycle; clear the watchdog; go to WAIT.
  - A refresh grant clears ref_pend in this cycle. If the counter also hits terminal count in this cycle, set wins: ref_pend stays 1 and no overrun pulse.
- WAIT:
  - On ctl_ready=1: capture ctl_rdata into rdata of the granted port if the command was a read; go to DONE.
  - Watchdog counts cycles. At count TIMEOUT with no ctl_ready: pulse timeout_err, go to DONE, rdata unchanged.
  - ctl_ready outside WAIT is ignored.
- DONE (1 cycle):
  - Pulse ackN for the granted port; refresh and timeout-on-refresh give no ack.
  - Timeout on a port still acks so the requester is freed; timeout_err marks the failure.
  - Update last_grant for port grants only; clear grant; go to IDLE.
- Latency: req sampled high in IDLE at edge k → ctl_valid during cycle k+1 → ctl_ready at cycle m → ackN in cycle m+1. Minimum req-to-ack is 3 cycles with ctl_ready the cycle after ctl_valid.
- Request inputs are not sampled outside IDLE. A request dropped before ack is a protocol violation; the transaction still completes.

Test Plan:
- Single read: req0=1 addr0=0x1000_0040, controller returns ctl_ready 4 cycles after ctl_valid with ctl_rdata=0xDEADBEEF → one ctl_valid with ctl_addr=0x1000_0040, ctl_write=0, grant=01, ack0 one pulse with rdata0=0xDEADBEEF, ack1 never.
- Tie/fairness: req0 and req1 held continuously, each a write → grants alternate 01,10,01,10 starting with port 0; each ack exactly once per transaction; no back-to-back double issue.
- Refresh priority: REFRESH_INTERVAL=16, req1 held high → every 16 cycles the next IDLE grant is 11 with ctl_refresh=1 and no ack; port1 is served between refreshes.
- Overrun: REFRESH_INTERVAL=8, controller delays ctl_ready 20 cycles on a port read → ref_overrun pulses while ref_pend is set, then exactly one refresh is issued afterwards.
- Timeout: TIMEOUT=10, ctl_ready never returned for req0 read → timeout_err pulse 10 cycles into WAIT, ack0 next cycle, rdata0 unchanged, FSM back to IDLE.
- Async reset mid-WAIT: drop reset while grant=10 → busy, grant, ctl_valid, ackN all 0 immediately without a clock edge; after release, port 0 wins the first tie.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Two-port SDRAM command arbiter with an internal auto-refresh scheduler.
// Serialises port/refresh transactions onto the controller and returns data/ack.
module sdram_port_arbiter #(
    parameter int REFRESH_INTERVAL = 780,
    parameter int TIMEOUT          = 255,
    parameter int AW               = 32,
    parameter int DW               = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          req0,
    input  logic          write0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic [1:0]    size0,
    input  logic [3:0]    burst0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,

    input  logic          req1,
    input  logic          write1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic [1:0]    size1,
    input  logic [3:0]    burst1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,

    output logic          ctl_valid,
    output logic          ctl_refresh,
    output logic          ctl_write,
    output logic [AW-1:0] ctl_addr,
    output logic [DW-1:0] ctl_wdata,
    output logic [1:0]    ctl_size,
    output logic [3:0]    ctl_burst,
    input  logic          ctl_ready,
    input  logic [DW-1:0] ctl_rdata,

    output logic [1:0]    grant,
    output logic          busy,
    output logic          timeout_err,
    output logic          ref_overrun
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_P0   = 2'b01;
    localparam logic [1:0] G_P1   = 2'b10;
    localparam logic [1:0] G_REF  = 2'b11;

    localparam int RCW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [RCW-1:0] REF_LAST = RCW'(REFRESH_INTERVAL - 1);
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

    state_t         state;
    state_t         state_next;
    logic [RCW-1:0] ref_cnt;
    logic           ref_tc;
    logic           ref_pend;
    logic           ref_issue;
    logic           last_grant;     // 0: port 0 served last, 1: port 1 served last
    logic [WDW-1:0] wd_cnt;
    logic [1:0]     pick;
    logic           elig0;
    logic           elig1;

    assign ref_tc = (ref_cnt == REF_LAST);

    always_comb begin
        state_next  = state;
        pick        = G_NONE;
        ack0        = 1'b0;
        ack1        = 1'b0;
        elig0       = 1'b0;
        elig1       = 1'b0;
        ctl_valid   = 1'b0;
        busy        = 1'b0;
        timeout_err = 1'b0;
        ref_issue   = 1'b0;
        ref_overrun = 1'b0;

        ack0        = (state == DONE) && (grant == G_P0);
        ack1        = (state == DONE) && (grant == G_P1);
        elig0       = req0 && !ack0;
        elig1       = req1 && !ack1;
        ctl_valid   = (state == ISSUE);
        busy        = (state != IDLE);
        ref_issue   = (state == ISSUE) && (grant == G_REF);
        // A refresh being issued on the terminal-count cycle is immediately re-armed, not an overrun
        ref_overrun = ref_tc && ref_pend && !ref_issue;

        case (state)
            IDLE: begin
                if (ref_pend) begin
                    pick = G_REF;
                end else if (elig0 && elig1) begin
                    pick = last_grant ? G_P0 : G_P1;
                end else if (elig0) begin
                    pick = G_P0;
                end else if (elig1) begin
                    pick = G_P1;
                end
                if (pick != G_NONE) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (ctl_ready) begin
                    state_next = DONE;
                end else if (wd_cnt == WD_LIMIT) begin
                    timeout_err = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ref_cnt     <= '0;
            ref_pend    <= 1'b0;
            last_grant  <= 1'b1;
            wd_cnt      <= '0;
            grant       <= G_NONE;
            ctl_refresh <= 1'b0;
            ctl_write   <= 1'b0;
            ctl_addr    <= '0;
            ctl_wdata   <= '0;
            ctl_size    <= '0;
            ctl_burst   <= '0;
            rdata0      <= '0;
            rdata1      <= '0;
        end else begin
            state   <= state_next;
            ref_cnt <= ref_tc ? '0 : ref_cnt + 1'b1;

            if (ref_tc) begin
                ref_pend <= 1'b1;
            end else if (ref_issue) begin
                ref_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick != G_NONE) begin
                        grant <= pick;
                        if (pick == G_REF) begin
                            ctl_refresh <= 1'b1;
                            ctl_write   <= 1'b0;
                            ctl_addr    <= '0;
                            ctl_wdata   <= '0;
                            ctl_size    <= '0;
                            ctl_burst   <= '0;
                        end else if (pick == G_P0) begin
                            ctl_refresh <= 1'b0;
                            ctl_write   <= write0;
                            ctl_addr    <= addr0;
                            ctl_wdata   <= wdata0;
                            ctl_size    <= size0;
                            ctl_burst   <= burst0;
                        end else begin
                            ctl_refresh <= 1'b0;
                            ctl_write   <= write1;
                            ctl_addr    <= addr1;
                            ctl_wdata   <= wdata1;
                            ctl_size    <= size1;
                            ctl_burst   <= burst1;
                        end
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                end
                WAIT: begin
                    if (ctl_ready) begin
                        if (!ctl_write && !ctl_refresh) begin
                            if (grant == G_P0) begin
                                rdata0 <= ctl_rdata;
                            end else if (grant == G_P1) begin
                                rdata1 <= ctl_rdata;
                            end
                        end
                    end else if (wd_cnt != WD_LIMIT) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (grant == G_P0) begin
                        last_grant <= 1'b0;
                    end else if (grant == G_P1) begin
                        last_grant <= 1'b1;
                    end
                    grant <= G_NONE;
                end
                default: begin
                    grant <= G_NONE;
                end
            endcase
        end
    end

endmodule
